// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD timer sequencer.
//   state_e   : controller state encoding (also driven onto the state output)
//   BCD_MAX   : terminal value of a digit when counting up
//   BCD_MIN   : terminal value of a digit when counting down
//   bcd_valid : true when a nibble holds a legal BCD digit (0..9)
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset (digit -> 0)
//   en_i          : step the digit by one this cycle
//   up_i          : 1 = count up (9 wraps to 0), 0 = count down (0 wraps to 9)
//   load_i        : synchronous load, has priority over en_i
//   load_val_i    : value taken on load_i
//   q_o           : current digit value
//   step_o        : value the digit would take if stepped (lets the controller see
//                   the post-tick count before committing)
//   term_o        : digit sits at its terminal value for the current direction
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] q_o,
  output logic [3:0] step_o,
  output logic       term_o
);

  logic [3:0] q_q, q_d;

  always_comb begin
    if (up_i) begin
      step_o = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      term_o = (q_q == BCD_MAX);
    end else begin
      step_o = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      term_o = (q_q == BCD_MIN);
    end
  end

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = step_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Sequencer for a cascaded multi-digit BCD counter (timer / stopwatch core).
// Loads a BCD preset, runs the digit chain up or down on a prescaled tick,
// supports pause/resume and flags completion.
// Parameters:
//   DIGITS   : number of BCD digits (count is 4*DIGITS bits, digit 0 in [3:0])
//   PRESCALE : clk cycles per count tick (>= 2)
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   clear    : synchronous clear to IDLE, count/target/prescaler -> 0
//   load     : latch preset/mode; rejected (err pulse) if any nibble > 9
//   preset   : BCD preset value
//   mode     : 0 = count up 0->preset, 1 = count down preset->0 (sampled on load)
//   start    : begin (from IDLE) or resume (from PAUSED)
//   pause    : hold counting while in RUN
//   count    : current BCD value
//   state    : 0 IDLE, 1 RUN, 2 PAUSED, 3 DONE
//   busy     : high in RUN
//   done     : one-cycle pulse on completion (or on each reload)
//   err      : one-cycle pulse on a rejected load
// Command priority each cycle: clear > load > pause > start.
// Build option: define AUTO_RELOAD_EN to make the endpoint tick reload the count
// and keep running (periodic timer) instead of stopping in DONE.
module bcd_timer_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] preset,
  input  logic                mode,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] count,
  output logic [1:0]          state,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] target_q, target_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [DIGITS-1:0] carry;     // all lower digits terminal -> this digit steps on a tick
  logic [DIGITS-1:0] dig_en;
  logic [DIGITS-1:0] dig_term;
  logic [CW-1:0]     dig_step;
  logic [CW-1:0]     cnt_tick;  // count as it would be after a tick
  logic [CW-1:0]     digit_val;
  logic              dig_load;
  logic              step_en;
  logic              preset_ok;
  logic [CW-1:0]     endpoint;

  // Counting down finishes at zero, counting up finishes at the target.
  assign endpoint = mode_q ? '0 : target_q;

  always_comb begin
    preset_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(preset[4*i +: 4])) begin
        preset_ok = 1'b0;
      end
    end
  end

  // Ripple the terminal flags up the chain and form the post-tick value.
  always_comb begin
    logic chain;
    chain = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      carry[i] = chain;
      chain    = chain & dig_term[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      cnt_tick[4*i +: 4] = carry[i] ? dig_step[4*i +: 4] : count[4*i +: 4];
    end
  end

  assign dig_en = carry & {DIGITS{step_en}};

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    mode_d    = mode_q;
    presc_d   = presc_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    dig_load  = 1'b0;
    digit_val = '0;
    step_en   = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      target_d = '0;
      presc_d  = '0;
      dig_load = 1'b1;
    end else if (load) begin
      // A rejected load only raises err; pause/start are still swallowed.
      if (!preset_ok) begin
        err_d = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        target_d  = preset;
        mode_d    = mode;
        presc_d   = '0;
        dig_load  = 1'b1;
        digit_val = mode ? preset : '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            presc_d = '0;
            // Already at the endpoint: finish without ever ticking.
            if (count == endpoint) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            // Prescaler is left where it is so resume finishes the period.
            state_d = ST_PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (cnt_tick == endpoint) begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              dig_load  = 1'b1;
              digit_val = mode_q ? target_q : '0;
`else
              step_en = 1'b1;
              state_d = ST_DONE;
`endif
            end else begin
              step_en = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          // Holds until clear or load.
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      mode_q   <= 1'b0;
      presc_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .en_i       (dig_en[gi]),
      .up_i       (~mode_q),
      .load_i     (dig_load),
      .load_val_i (digit_val[4*gi +: 4]),
      .q_o        (count[4*gi +: 4]),
      .step_o     (dig_step[4*gi +: 4]),
      .term_o     (dig_term[gi])
    );
  end

  assign state = state_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign err   = err_q;

endmodule
